pipe_hazard_ctrl: RTL and testbench

Central stall/flush controller for the five-stage pipeline. Each cycle it computes the `write_enable`/`flush` pair for the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus `pc_we`. Inputs are load-use hazards, taken branches, data-memory wait, exception flush and a multi-cycle multiply/divide busy tracker. It sits directly upstream of every pipeline register and drives their control inputs.

---
 rtl/hazard_pkg.sv | 40 ++++
 rtl/pipe_hazard_ctrl_if.sv | 51 +++++
 rtl/md_busy_tracker.sv | 69 ++++++
 rtl/pipe_hazard_ctrl.sv | 115 +++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the mul/div tracker state enum, the default mul/div latencies,
// the register-zero constant, the control-bundle struct and a width helper.
package hazard_pkg;

    localparam int unsigned REG_W       = 5;
    localparam int unsigned PERF_W      = 32;
    localparam int unsigned MUL_LAT_DEF = 4;
    localparam int unsigned DIV_LAT_DEF = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } md_state_e;

    // Write-enable / flush bundle for the pipeline registers plus PC.
    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic idex_we;
        logic exmem_we;
        logic memwb_we;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_flush;
    } pipe_ctrl_t;

    // Down-counter width for the longer of the two latencies.
    // The minimum is one bit so that a latency of 1 still yields a legal vector.
    function automatic int unsigned md_cnt_width(input int unsigned mul_lat,
                                                 input int unsigned div_lat);
        int unsigned m;
        m = (mul_lat > div_lat) ? mul_lat : div_lat;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: hazard sources from the pipeline, and the per-stage
// write-enable/flush controls, md_busy and perf counters going back.
// Modports: master = pipeline side, slave = hazard controller.
interface pipe_hazard_ctrl_if;
    import hazard_pkg::*;

    logic              flush_all;
    logic              mem_wait;
    logic              br_taken_ex;
    logic              ex_mem_read;
    logic [REG_W-1:0]  ex_rd;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic              id_uses_rs;
    logic              id_uses_rt;
    logic              id_hilo_dep;
    logic              md_start;
    logic              md_is_div;

    logic              pc_we;
    logic              ifid_we;
    logic              idex_we;
    logic              exmem_we;
    logic              memwb_we;
    logic              ifid_flush;
    logic              idex_flush;
    logic              exmem_flush;
    logic              memwb_flush;
    logic              md_busy;
    logic [PERF_W-1:0] stall_cycles;
    logic [PERF_W-1:0] flush_events;

    modport master (
        output flush_all, mem_wait, br_taken_ex, ex_mem_read, ex_rd,
               id_rs, id_rt, id_uses_rs, id_uses_rt, id_hilo_dep,
               md_start, md_is_div,
        input  pc_we, ifid_we, idex_we, exmem_we, memwb_we,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               md_busy, stall_cycles, flush_events
    );

    modport slave (
        input  flush_all, mem_wait, br_taken_ex, ex_mem_read, ex_rd,
               id_rs, id_rt, id_uses_rs, id_uses_rt, id_hilo_dep,
               md_start, md_is_div,
        output pc_we, ifid_we, idex_we, exmem_we, memwb_we,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               md_busy, stall_cycles, flush_events
    );

endinterface

// File: rtl/md_busy_tracker.sv
// Multiply/divide HI/LO busy tracker.
// A start loads LAT-1 into a down-counter and enters BUSY; BUSY lasts exactly
// LAT cycles. A start while BUSY restarts the count; force_idle_i wins over all.
// Ports: clk, rst (async, active-high), md_start_i (already qualified),
//        md_is_div_i, force_idle_i, md_busy_o (registered).
module md_busy_tracker
    import hazard_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic md_start_i,
    input  logic md_is_div_i,
    input  logic force_idle_i,
    output logic md_busy_o
);

    localparam int unsigned CNT_W = md_cnt_width(MUL_LAT, DIV_LAT);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (md_start_i) begin
                    state_d = BUSY;
                    cnt_d   = md_is_div_i ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
                end
            end
            BUSY: begin
                if (md_start_i) begin
                    cnt_d = md_is_div_i ? CNT_W'(DIV_LAT - 1) : CNT_W'(MUL_LAT - 1);
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (force_idle_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    assign md_busy_o = (state_q == BUSY);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the five-stage pipeline.
// Computes write-enable/flush for IF/ID, ID/EX, EX/MEM, MEM/WB and pc_we from
// flush_all > mem_wait > br_taken_ex > (load-use | mul/div) stall > normal.
// Ports: clk, rst (async, active-high), bus (pipe_hazard_ctrl_if.slave).
// Optional: HAZARD_PERF_EN enables the stall_cycles / flush_events counters;
// without it both read as zero and no counter flops exist.
module pipe_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int unsigned MUL_LAT = MUL_LAT_DEF,
    parameter int unsigned DIV_LAT = DIV_LAT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  bus
);

    logic       load_use_c;
    logic       md_hazard_c;
    logic       stall_c;
    logic       md_start_c;
    logic       md_busy;
    pipe_ctrl_t ctrl_c;

    // Load in EX feeding a live source of the instruction in ID.
    assign load_use_c = bus.ex_mem_read && (bus.ex_rd != REG_ZERO) &&
                        ((bus.id_uses_rs && (bus.id_rs == bus.ex_rd)) ||
                         (bus.id_uses_rt && (bus.id_rt == bus.ex_rd)));

    assign md_hazard_c = bus.id_hilo_dep && (md_busy || bus.md_start);
    assign stall_c     = load_use_c || md_hazard_c;

    // A mul/div squashed by a branch or exception never occupies HI/LO.
    assign md_start_c = bus.md_start && !bus.br_taken_ex && !bus.flush_all;

    md_busy_tracker #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) u_md_busy_tracker (
        .clk          (clk),
        .rst          (rst),
        .md_start_i   (md_start_c),
        .md_is_div_i  (bus.md_is_div),
        .force_idle_i (bus.flush_all),
        .md_busy_o    (md_busy)
    );

    // Priority mux for the pipeline-register controls.
    always_comb begin
        ctrl_c = '{pc_we: 1'b1, ifid_we: 1'b1, idex_we: 1'b1, exmem_we: 1'b1,
                   memwb_we: 1'b1, default: 1'b0};
        if (rst) begin
            ctrl_c = '0;
        end else if (bus.flush_all) begin
            ctrl_c.ifid_flush  = 1'b1;
            ctrl_c.idex_flush  = 1'b1;
            ctrl_c.exmem_flush = 1'b1;
        end else if (bus.mem_wait) begin
            ctrl_c = '0;
        end else if (bus.br_taken_ex) begin
            ctrl_c.ifid_flush = 1'b1;
            ctrl_c.idex_flush = 1'b1;
        end else if (stall_c) begin
            // Hold PC and IF/ID, push a bubble into ID/EX.
            ctrl_c.pc_we      = 1'b0;
            ctrl_c.ifid_we    = 1'b0;
            ctrl_c.idex_flush = 1'b1;
        end
    end

    assign bus.pc_we       = ctrl_c.pc_we;
    assign bus.ifid_we     = ctrl_c.ifid_we;
    assign bus.idex_we     = ctrl_c.idex_we;
    assign bus.exmem_we    = ctrl_c.exmem_we;
    assign bus.memwb_we    = ctrl_c.memwb_we;
    assign bus.ifid_flush  = ctrl_c.ifid_flush;
    assign bus.idex_flush  = ctrl_c.idex_flush;
    assign bus.exmem_flush = ctrl_c.exmem_flush;
    assign bus.memwb_flush = ctrl_c.memwb_flush;
    assign bus.md_busy     = md_busy;

`ifdef HAZARD_PERF_EN
    logic              stall_evt_c;
    logic              flush_evt_c;
    logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [PERF_W-1:0] flush_events_q, flush_events_d;

    // Count only events that actually take effect after prioritisation.
    always_comb begin
        stall_evt_c    = !bus.flush_all &&
                         (bus.mem_wait || (!bus.br_taken_ex && stall_c));
        flush_evt_c    = bus.flush_all || (!bus.mem_wait && bus.br_taken_ex);
        stall_cycles_d = stall_cycles_q + PERF_W'(stall_evt_c);
        flush_events_d = flush_events_q + PERF_W'(flush_evt_c);
    end

    // Wrapping performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_events_q <= flush_events_d;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_events = flush_events_q;
`else
    assign bus.stall_cycles = '0;
    assign bus.flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MUL_LAT=4, DIV_LAT=32).
// Table of single-cycle control vectors, then hand-written multi-cycle
// sequences for mul/div busy, flush_all, mem_wait, async reset and counters.
module tb_pipe_hazard_ctrl;

    localparam int unsigned MUL_LAT = 4;
    localparam int unsigned DIV_LAT = 32;

`ifdef HAZARD_PERF_EN
    localparam logic [31:0] EXP_STALLS  = 32'd3;
    localparam logic [31:0] EXP_FLUSHES = 32'd2;
`else
    localparam logic [31:0] EXP_STALLS  = 32'd0;
    localparam logic [31:0] EXP_FLUSHES = 32'd0;
`endif

    // {pc,ifid,idex,exmem,memwb we ; ifid,idex,exmem,memwb flush}
    localparam logic [8:0] O_NORM  = 9'b11111_0000;
    localparam logic [8:0] O_STALL = 9'b00111_0100;
    localparam logic [8:0] O_BR    = 9'b11111_1100;
    localparam logic [8:0] O_FLUSH = 9'b11111_1110;
    localparam logic [8:0] O_ZERO  = 9'b00000_0000;

    typedef struct {
        logic       fa, mw, br, mr;
        logic [4:0] exrd, rs, rt;
        logic       urs, urt, hilo;
        logic [8:0] exp;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] outs();
        return {bus.pc_we, bus.ifid_we, bus.idex_we, bus.exmem_we, bus.memwb_we,
                bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.flush_all   = 1'b0;
        bus.mem_wait    = 1'b0;
        bus.br_taken_ex = 1'b0;
        bus.ex_mem_read = 1'b0;
        bus.ex_rd       = 5'd0;
        bus.id_rs       = 5'd0;
        bus.id_rt       = 5'd0;
        bus.id_uses_rs  = 1'b0;
        bus.id_uses_rt  = 1'b0;
        bus.id_hilo_dep = 1'b0;
        bus.md_start    = 1'b0;
        bus.md_is_div   = 1'b0;
    endtask

    task automatic load_use();
        bus.ex_mem_read = 1'b1;
        bus.ex_rd       = 5'd8;
        bus.id_rs       = 5'd8;
        bus.id_uses_rs  = 1'b1;
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[12];
        total = 0;
        bad   = 0;

        vecs[0]  = '{0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0,0, O_NORM};   // quiet
        vecs[1]  = '{0,0,0,1, 5'd8, 5'd8, 5'd3, 1,0,0, O_STALL};  // load-use rs
        vecs[2]  = '{0,0,0,1, 5'd9, 5'd2, 5'd9, 0,1,0, O_STALL};  // load-use rt
        vecs[3]  = '{0,0,0,1, 5'd0, 5'd0, 5'd0, 1,1,0, O_NORM};   // ex_rd = r0
        vecs[4]  = '{0,0,0,1, 5'd8, 5'd8, 5'd8, 0,0,0, O_NORM};   // sources unused
        vecs[5]  = '{0,0,0,0, 5'd8, 5'd8, 5'd8, 1,1,0, O_NORM};   // not a load
        vecs[6]  = '{0,0,1,1, 5'd8, 5'd8, 5'd0, 1,0,0, O_BR};     // branch beats stall
        vecs[7]  = '{0,1,0,1, 5'd8, 5'd8, 5'd0, 1,0,0, O_ZERO};   // mem_wait beats stall
        vecs[8]  = '{1,1,1,1, 5'd8, 5'd8, 5'd0, 1,0,0, O_FLUSH};  // flush_all beats all
        vecs[9]  = '{0,0,0,0, 5'd0, 5'd0, 5'd0, 0,0,1, O_NORM};   // hilo dep, md idle
        vecs[10] = '{0,1,0,0, 5'd0, 5'd0, 5'd0, 0,0,0, O_ZERO};   // mem_wait only
        vecs[11] = '{0,1,1,0, 5'd0, 5'd0, 5'd0, 0,0,0, O_ZERO};   // mem_wait beats branch

        idle_inputs();
        rst = 1'b1;
        #2;
        chk("rst_ctrl",   32'(outs()), 32'(O_ZERO));
        chk("rst_busy",   32'(bus.md_busy), 32'd0);
        chk("rst_stalls", bus.stall_cycles, 32'd0);
        chk("rst_flush",  bus.flush_events, 32'd0);
        tick();
        rst = 1'b0;

        // Single-cycle control table.
        for (int i = 0; i < 12; i++) begin
            tick();
            bus.flush_all   = vecs[i].fa;
            bus.mem_wait    = vecs[i].mw;
            bus.br_taken_ex = vecs[i].br;
            bus.ex_mem_read = vecs[i].mr;
            bus.ex_rd       = vecs[i].exrd;
            bus.id_rs       = vecs[i].rs;
            bus.id_rt       = vecs[i].rt;
            bus.id_uses_rs  = vecs[i].urs;
            bus.id_uses_rt  = vecs[i].urt;
            bus.id_hilo_dep = vecs[i].hilo;
            #1;
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
        end
        tick();
        idle_inputs();

        // Load-use lasts exactly one cycle.
        tick();
        load_use();
        #1;
        chk("lu_stall", 32'(outs()), 32'(O_STALL));
        tick();
        idle_inputs();
        #1;
        chk("lu_after", 32'(outs()), 32'(O_NORM));

        // Multiply then dependent HI/LO reader: stall start cycle + 4.
        tick();
        bus.md_start    = 1'b1;
        bus.md_is_div   = 1'b0;
        bus.id_hilo_dep = 1'b1;
        #1;
        chk("mul_c0_busy", 32'(bus.md_busy), 32'd0);
        chk("mul_c0_ctrl", 32'(outs()), 32'(O_STALL));
        for (int k = 1; k <= 5; k++) begin
            tick();
            bus.md_start = 1'b0;
            #1;
            chk($sformatf("mul_c%0d_busy", k), 32'(bus.md_busy), (k <= 4) ? 32'd1 : 32'd0);
            chk($sformatf("mul_c%0d_ctrl", k), 32'(outs()),
                (k <= 4) ? 32'(O_STALL) : 32'(O_NORM));
        end
        tick();
        idle_inputs();

        // Divide, then flush_all in cycle 10 kills the busy tracker.
        tick();
        bus.md_start  = 1'b1;
        bus.md_is_div = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            tick();
            bus.md_start  = 1'b0;
            bus.flush_all = (k == 10);
            #1;
            chk($sformatf("div_fl_c%0d_busy", k), 32'(bus.md_busy), (k <= 10) ? 32'd1 : 32'd0);
            if (k == 10) chk("div_fl_ctrl", 32'(outs()), 32'(O_FLUSH));
        end
        tick();
        idle_inputs();

        // Divide with mem_wait held: freezes everything, busy still ends on time.
        tick();
        bus.md_start  = 1'b1;
        bus.md_is_div = 1'b1;
        for (int k = 1; k <= 34; k++) begin
            tick();
            bus.md_start = 1'b0;
            bus.mem_wait = (k >= 2);
            #1;
            chk($sformatf("div_mw_c%0d_busy", k), 32'(bus.md_busy), (k <= 32) ? 32'd1 : 32'd0);
            if (k == 5 || k == 33)
                chk($sformatf("div_mw_c%0d_ctrl", k), 32'(outs()), 32'(O_ZERO));
        end
        tick();
        idle_inputs();

        // Async reset in the middle of BUSY drops md_busy without a clock edge.
        tick();
        bus.md_start = 1'b1;
        tick();
        bus.md_start = 1'b0;
        #1;
        chk("arst_pre_busy", 32'(bus.md_busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.md_busy), 32'd0);
        chk("arst_ctrl", 32'(outs()), 32'(O_ZERO));
        tick();
        rst = 1'b0;

        // Counters: 3 load-use stalls and 2 branches from a clean reset.
        do_reset();
        for (int n = 0; n < 3; n++) begin
            tick();
            load_use();
            tick();
            idle_inputs();
        end
        for (int n = 0; n < 2; n++) begin
            tick();
            bus.br_taken_ex = 1'b1;
            tick();
            idle_inputs();
        end
        tick();
        chk("perf_stalls", bus.stall_cycles, EXP_STALLS);
        chk("perf_flush",  bus.flush_events, EXP_FLUSHES);
        rst = 1'b1;
        #1;
        chk("perf_rst_stalls", bus.stall_cycles, 32'd0);
        chk("perf_rst_flush",  bus.flush_events, 32'd0);
        tick();
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
